// File: rtl/audio_pkg.sv
// Shared constants and the signed saturation helper for the 48 kHz audio resampler.
package audio_pkg;

    localparam int AUDIO_RATE = 48000;
    localparam int IN_W       = 18;
    localparam int OUT_W      = 16;

    localparam logic [1:0] VOL_MUTE = 2'd0;
    localparam logic [1:0] VOL_M12  = 2'd1;
    localparam logic [1:0] VOL_M6   = 2'd2;
    localparam logic [1:0] VOL_0DB  = 2'd3;

    // Clamp a 19-bit signed value into OUT_W bits; in range when all bits above the sign agree.
    function automatic logic signed [OUT_W-1:0] saturateOut(input logic signed [IN_W:0] v);
        logic signed [OUT_W-1:0] r;
        if ((&v[IN_W:OUT_W-1]) || !(|v[IN_W:OUT_W-1])) begin
            r = v[OUT_W-1:0];
        end else if (v[IN_W]) begin
            r = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
            r = {1'b0, {(OUT_W-1){1'b1}}};
        end
        return r;
    endfunction

endpackage

// File: rtl/audio_iir_lp.sv
// One audio channel: IIR low-pass, optional DC blocker (AUDIO_DC_BLOCK_EN), saturation and volume.
// The sample output is combinational from filter state, so a tick always sees the pre-strobe value.
module audio_iir_lp
    import audio_pkg::*;
#(
    parameter int LP_SHIFT = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_strobe,
    input  logic signed [IN_W-1:0]  i_x,
    input  logic [1:0]              i_vol,
    output logic signed [OUT_W-1:0] o_sample
);

    localparam int SW = IN_W + 1 + LP_SHIFT;

    logic signed [SW-1:0]    r_s;
    logic signed [SW-1:0]    w_x_ext;
    logic signed [IN_W-1:0]  w_y;
    logic signed [IN_W:0]    w_conv;
    logic signed [IN_W:0]    w_half;
    logic signed [OUT_W-1:0] w_sat;

    assign w_x_ext = {{(SW-IN_W){i_x[IN_W-1]}}, i_x};
    assign w_y     = r_s[LP_SHIFT +: IN_W];

    // State carries LP_SHIFT extra fraction bits so the DC gain is exactly one.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s <= '0;
        end else if (i_strobe) begin
            r_s <= r_s + w_x_ext - (r_s >>> LP_SHIFT);
        end
    end

`ifdef AUDIO_DC_BLOCK_EN
    localparam int DW = 26;

    logic signed [DW-1:0] r_d;
    logic signed [DW-1:0] w_y_ext;
    logic signed [IN_W:0] w_d_avg;

    assign w_y_ext = {{(DW-IN_W){w_y[IN_W-1]}}, w_y};
    assign w_d_avg = {r_d[DW-1], r_d[DW-1:8]};

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_d <= '0;
        end else if (i_strobe) begin
            r_d <= r_d + w_y_ext - (r_d >>> 8);
        end
    end

    assign w_conv = {w_y[IN_W-1], w_y} - w_d_avg;
`else
    assign w_conv = {w_y[IN_W-1], w_y};
`endif

    assign w_half = w_conv >>> 1;
    assign w_sat  = saturateOut(w_half);

    always_comb begin
        o_sample = '0;
        case (i_vol)
            VOL_0DB:  o_sample = w_sat;
            VOL_M6:   o_sample = w_sat >>> 1;
            VOL_M12:  o_sample = w_sat >>> 2;
            VOL_MUTE: o_sample = '0;
            default:  o_sample = '0;
        endcase
    end

endmodule

// File: rtl/audio_resampler_48k.sv
// 48 kHz resampler top: phase-accumulator tick generator, clk_audio and registered L/R samples.
module audio_resampler_48k
    import audio_pkg::*;
#(
    parameter int CLK_HZ_PAL  = 31527954,
    parameter int CLK_HZ_NTSC = 32727264,
    parameter int LP_SHIFT    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ntscmode,
    input  logic                    in_strobe,
    input  logic signed [IN_W-1:0]  audio_l,
    input  logic signed [IN_W-1:0]  audio_r,
    input  logic [1:0]              volume,
    output logic                    clk_audio,
    output logic signed [OUT_W-1:0] sample_l,
    output logic signed [OUT_W-1:0] sample_r,
    output logic                    sample_valid
);

    localparam logic [31:0] PHASE_INC = 32'(2 * AUDIO_RATE);

    logic [31:0]             r_acc;
    logic                    r_ntsc_q;
    logic                    r_clk_audio;
    logic signed [OUT_W-1:0] r_sample_l;
    logic signed [OUT_W-1:0] r_sample_r;
    logic                    r_valid;

    logic [31:0]             w_mod;
    logic [31:0]             w_sum;
    logic                    w_chg;
    logic                    w_tick;
    logic signed [OUT_W-1:0] w_ch_l;
    logic signed [OUT_W-1:0] w_ch_r;

    audio_iir_lp #(.LP_SHIFT(LP_SHIFT)) u_chan_l (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_strobe (in_strobe),
        .i_x      (audio_l),
        .i_vol    (volume),
        .o_sample (w_ch_l)
    );

    audio_iir_lp #(.LP_SHIFT(LP_SHIFT)) u_chan_r (
        .i_clk    (clk),
        .i_reset  (reset),
        .i_strobe (in_strobe),
        .i_x      (audio_r),
        .i_vol    (volume),
        .o_sample (w_ch_r)
    );

    assign w_mod  = ntscmode ? 32'(CLK_HZ_NTSC) : 32'(CLK_HZ_PAL);
    assign w_sum  = r_acc + PHASE_INC;
    assign w_chg  = ntscmode ^ r_ntsc_q;
    assign w_tick = !w_chg && (w_sum >= w_mod);

    // A mode change restarts the phase without toggling, so no clk_audio level is cut short.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_ntsc_q    <= ntscmode;
            r_clk_audio <= 1'b0;
            r_sample_l  <= '0;
            r_sample_r  <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_ntsc_q <= ntscmode;
            r_valid  <= 1'b0;
            if (w_chg) begin
                r_acc <= '0;
            end else if (w_tick) begin
                r_acc       <= w_sum - w_mod;
                r_clk_audio <= ~r_clk_audio;
                if (!r_clk_audio) begin
                    r_sample_l <= w_ch_l;
                    r_sample_r <= w_ch_r;
                    r_valid    <= 1'b1;
                end
            end else begin
                r_acc <= w_sum;
            end
        end
    end

    assign clk_audio    = r_clk_audio;
    assign sample_l     = r_sample_l;
    assign sample_r     = r_sample_r;
    assign sample_valid = r_valid;

endmodule

// File: tb/tb_audio_resampler_48k.sv
// Self-checking bench for audio_resampler_48k: tick rate, mode switch, filter/volume, saturation, reset.
// Honours AUDIO_DC_BLOCK_EN to select the DC-blocker scenario instead of the plain filter scenarios.
module tb_audio_resampler_48k;

    localparam int CLK_HZ_PAL  = 31527954;
    localparam int CLK_HZ_NTSC = 32727264;
    localparam int LP_SHIFT    = 4;
    localparam int PHASE_INC   = 96000;
    localparam int PERIOD_CLKS = 8000;
    localparam int WAIT_LIMIT  = 2000;

    typedef struct {
        string tag;
        int    expL;
        int    expR;
    } expect_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               ntscmode = 1'b0;
    logic               in_strobe = 1'b0;
    logic signed [17:0] audio_l = '0;
    logic signed [17:0] audio_r = '0;
    logic [1:0]         volume = 2'd3;
    logic               clk_audio;
    logic signed [15:0] sample_l;
    logic signed [15:0] sample_r;
    logic               sample_valid;

    int      nChecks = 0;
    int      nErrors = 0;
    expect_t sbQ[$];
    logic    prevClkAudio = 1'b0;
    bit      wrapWatch = 1'b0;
    bit      wrapSeen = 1'b0;

    audio_resampler_48k #(
        .CLK_HZ_PAL  (CLK_HZ_PAL),
        .CLK_HZ_NTSC (CLK_HZ_NTSC),
        .LP_SHIFT    (LP_SHIFT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ntscmode     (ntscmode),
        .in_strobe    (in_strobe),
        .audio_l      (audio_l),
        .audio_r      (audio_r),
        .volume       (volume),
        .clk_audio    (clk_audio),
        .sample_l     (sample_l),
        .sample_r     (sample_r),
        .sample_valid (sample_valid)
    );

    always #5 clk = ~clk;

    initial begin
        #10_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Returns the expected value when the actual lies within tolerance, else the actual itself.
    function automatic int near(input int actual, input int expected, input int tol);
        return (actual >= expected - tol && actual <= expected + tol) ? expected : actual;
    endfunction

    // Every sample_valid must land in the first cycle of a clk_audio high phase.
    always @(negedge clk) begin
        if (sample_valid === 1'b1) begin
            checkOutput("validOnRise", int'({prevClkAudio, clk_audio}), 1);
            if (wrapWatch && (sample_l < 0 || sample_r > 0)) wrapSeen = 1'b1;
        end
        prevClkAudio = clk_audio;
    end

    task automatic applyStimulus(input int l, input int r, input int vol, input bit strobe);
        audio_l   = 18'(l);
        audio_r   = 18'(r);
        volume    = 2'(vol);
        in_strobe = strobe;
    endtask

    task automatic applyReset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic waitValid(output bit got);
        got = 1'b0;
        for (int i = 0; i < WAIT_LIMIT; i++) begin
            @(negedge clk);
            if (sample_valid === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic expectSample(input string tag, input int eL, input int eR);
        expect_t e;
        bit      got;
        e.tag  = tag;
        e.expL = eL;
        e.expR = eR;
        sbQ.push_back(e);
        waitValid(got);
        e = sbQ.pop_front();
        checkOutput({e.tag, "_valid"}, int'(got), 1);
        if (got) begin
            checkOutput({e.tag, "_l"}, int'(sample_l), e.expL);
            checkOutput({e.tag, "_r"}, int'(sample_r), e.expR);
        end
    endtask

    task automatic countWindow(input int nClk, output int toggles, output int rises);
        logic lvl;
        toggles = 0;
        rises   = 0;
        lvl     = clk_audio;
        repeat (nClk) begin
            @(negedge clk);
            if (clk_audio !== lvl) toggles++;
            if (sample_valid === 1'b1) rises++;
            lvl = clk_audio;
        end
    endtask

    // Edges from the mode change until clk_audio toggles: one dead edge plus a full restart from 0.
    task automatic modeSwitch(input logic newMode, input string tag, input int modulus);
        logic lvl;
        int   n;
        @(negedge clk);
        ntscmode = newMode;
        lvl      = clk_audio;
        n        = 0;
        for (int i = 1; i <= WAIT_LIMIT; i++) begin
            @(posedge clk);
            #1;
            if (clk_audio !== lvl) begin
                n = i;
                break;
            end
        end
        checkOutput(tag, n, (modulus + PHASE_INC - 1) / PHASE_INC + 1);
        @(negedge clk);
    endtask

    task automatic checkPeriod(input string tag, input int modulus);
        int tg;
        int rs;
        int expT;
        countWindow(PERIOD_CLKS, tg, rs);
        expT = int'(longint'(PERIOD_CLKS) * PHASE_INC / modulus);
        checkOutput({tag, "_toggles"}, near(tg, expT, 1), expT);
        checkOutput({tag, "_valids"}, near(rs, (expT + 1) / 2, 1), (expT + 1) / 2);
    endtask

    initial begin
        bit got;
        int magL;

        applyStimulus(0, 0, 3, 1'b0);
        applyReset();
        checkOutput("rst_clkAudio", int'(clk_audio), 0);
        checkOutput("rst_l", int'(sample_l), 0);
        checkOutput("rst_r", int'(sample_r), 0);
        checkOutput("rst_valid", int'(sample_valid), 0);

        checkPeriod("pal", CLK_HZ_PAL);
        modeSwitch(1'b1, "toNtsc_edges", CLK_HZ_NTSC);
        applyReset();
        checkPeriod("ntsc", CLK_HZ_NTSC);
        modeSwitch(1'b0, "toPal_edges", CLK_HZ_PAL);

        // Reset while outputs are live; the restart must again load on a clk_audio rise.
        applyReset();
        applyStimulus(8000, -8000, 3, 1'b1);
        repeat (400) @(negedge clk);
        waitValid(got);
        checkOutput("preRst_nonzero", int'(got && sample_l != 0 && sample_r != 0), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midRst_clkAudio", int'(clk_audio), 0);
        checkOutput("midRst_l", int'(sample_l), 0);
        checkOutput("midRst_r", int'(sample_r), 0);
        checkOutput("midRst_valid", int'(sample_valid), 0);
        reset = 1'b0;
        waitValid(got);
        checkOutput("postRst_valid", int'(got), 1);

`ifdef AUDIO_DC_BLOCK_EN
        applyReset();
        applyStimulus(8000, 0, 3, 1'b1);
        repeat (65536) @(negedge clk);
        waitValid(got);
        checkOutput("dcBlock_valid", int'(got), 1);
        magL = (sample_l < 0) ? -int'(sample_l) : int'(sample_l);
        checkOutput("dcBlock_l", (magL < 64) ? 0 : int'(sample_l), 0);
`else
        // Step response: y settles to x, output is x/2 then volume-shifted (floor for negatives).
        applyReset();
        applyStimulus(4000, -4002, 3, 1'b1);
        repeat (400) @(negedge clk);
        expectSample("stepVol3", 2000, -2001);
        volume = 2'd2;
        expectSample("stepVol2", 1000, -1001);
        volume = 2'd1;
        expectSample("stepVol1", 500, -501);
        volume = 2'd0;
        expectSample("stepVol0", 0, 0);

        wrapSeen  = 1'b0;
        wrapWatch = 1'b1;
        applyStimulus(131071, -131072, 3, 1'b1);
        repeat (400) @(negedge clk);
        expectSample("satVol3", 32767, -32768);
        volume = 2'd2;
        expectSample("satVol2", 16383, -16384);
        wrapWatch = 1'b0;
        checkOutput("satNoWrap", int'(wrapSeen), 0);

        applyStimulus(8000, -131072, 3, 1'b1);
        repeat (400) @(negedge clk);
        expectSample("noDcBlock", 4000, -32768);
        magL = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

endmodule
